// File: rtl/timer_pkg.sv
// Shared types and widths for the timer control slice.
package timer_pkg;

    localparam int unsigned CNT_W = 8;

    typedef enum logic {IDLE, RUN} timer_state_t;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/timer_prescaler.sv
// Clock-enable generator: tick fires once every presc+1 cycles while running.
module timer_prescaler #(
    parameter int unsigned PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               load,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt;

    // Internal enable into the counter; only the divider state is registered.
    assign tick = run && (cnt == presc);

    // Divider count, cleared on reset or when a run is launched.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Timer sequencing: run FSM, prescaled up-counter, shadow/active compare bank, sticky flags.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned NUM_COMP = 3,
    parameter int unsigned PRESC_W  = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           one_shot,
    input  logic [CNT_W-1:0]               period,
    input  logic [PRESC_W-1:0]             presc,
    input  logic [NUM_COMP-1:0]            match_wr,
    input  logic [CNT_W-1:0]               match_wdata,
    input  logic [NUM_COMP-1:0]            flag_clr,
    input  logic [NUM_COMP-1:0]            match,
    output logic                           en,
    output logic [CNT_W-1:0]               counter_value,
    output logic [NUM_COMP-1:0][CNT_W-1:0] match_value,
    output logic [NUM_COMP-1:0]            flag,
    output logic                           overflow,
    output logic [NUM_COMP-1:0]            shadow_pend
);

    timer_state_t              state;
    logic                      tick;
    logic                      load;
    logic                      run;
    logic                      wrap;
    cnt_t [NUM_COMP-1:0]       shadow;
    logic [NUM_COMP-1:0]       match_d;

    assign run  = (state == RUN);
    assign load = (state == IDLE) && start && !stop;
    // Period boundary: a tick that is actually applied while the count sits at period.
    assign wrap = run && tick && !stop && (counter_value == period);

    timer_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .load  (load),
        .presc (presc),
        .tick  (tick)
    );

    // Run/idle FSM with counter, en and overflow registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            en            <= 1'b0;
            counter_value <= '0;
            overflow      <= 1'b0;
        end else begin
            overflow <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state         <= RUN;
                        en            <= 1'b1;
                        counter_value <= '0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                        en    <= 1'b0;
                    end else if (tick) begin
                        if (counter_value == period) begin
                            counter_value <= '0;
                            overflow      <= 1'b1;
                            if (one_shot) begin
                                state <= IDLE;
                                en    <= 1'b0;
                            end
                        end else begin
                            counter_value <= counter_value + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    en    <= 1'b0;
                end
            endcase
        end
    end

    // Double-buffered compare bank; active follows shadow only at a period boundary while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow      <= '0;
            match_value <= '0;
            shadow_pend <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_COMP; i++) begin
                if (wrap && shadow_pend[i]) begin
                    match_value[i] <= shadow[i];
                end
                if (match_wr[i]) begin
                    shadow[i] <= match_wdata;
                    if (!run) begin
                        match_value[i] <= match_wdata;
                    end
                    shadow_pend[i] <= run;
                end else if (wrap) begin
                    shadow_pend[i] <= 1'b0;
                end
            end
        end
    end

    // Sticky flags set on a rising match edge while enabled; set beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_d <= '0;
            flag    <= '0;
        end else begin
            match_d <= match;
            flag    <= (flag & ~flag_clr) | (match & ~match_d & {NUM_COMP{en}});
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with a behavioural output stage closing the match loop.
module tb_timer_ctrl;

    localparam int unsigned NC = 3;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic                 stop;
    logic                 one_shot;
    logic [7:0]           period;
    logic [7:0]           presc;
    logic [NC-1:0]        match_wr;
    logic [7:0]           match_wdata;
    logic [NC-1:0]        flag_clr;
    logic [NC-1:0]        match;
    logic                 en;
    logic [7:0]           counter_value;
    logic [NC-1:0][7:0]   match_value;
    logic [NC-1:0]        flag;
    logic                 overflow;
    logic [NC-1:0]        shadow_pend;

    logic                 manual;
    logic [NC-1:0]        match_force;
    logic [NC-1:0]        auto_match;

    int n_cmp;
    int n_err;

    timer_ctrl #(
        .NUM_COMP (NC),
        .PRESC_W  (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .one_shot      (one_shot),
        .period        (period),
        .presc         (presc),
        .match_wr      (match_wr),
        .match_wdata   (match_wdata),
        .flag_clr      (flag_clr),
        .match         (match),
        .en            (en),
        .counter_value (counter_value),
        .match_value   (match_value),
        .flag          (flag),
        .overflow      (overflow),
        .shadow_pend   (shadow_pend)
    );

    // Output stage model: equality compare, overridable for flag-edge tests.
    always_comb begin
        for (int i = 0; i < int'(NC); i++) begin
            auto_match[i] = en && (counter_value == match_value[i]);
        end
        match = manual ? match_force : auto_match;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] os_cnt [9];
        logic       os_ovf [9];
        logic       os_en  [9];
        logic [7:0] prev;
        int         ovf_seen;
        bit         hit_zero;

        n_cmp = 0; n_err = 0;
        rst = 1'b1; start = 1'b0; stop = 1'b0; one_shot = 1'b0;
        period = 8'd4; presc = 8'd0; match_wr = '0; match_wdata = '0;
        flag_clr = '0; manual = 1'b0; match_force = '0;

        // Reset state
        step(); step();
        chk("rst_en", 32'(en), 32'(0));
        chk("rst_cnt", 32'(counter_value), 32'(0));
        chk("rst_mv", 32'(match_value), 32'(0));
        chk("rst_flag", 32'(flag), 32'(0));
        chk("rst_ovf", 32'(overflow), 32'(0));
        chk("rst_pend", 32'(shadow_pend), 32'(0));
        rst = 1'b0;

        // IDLE writes go straight to active
        match_wr = 3'b001; match_wdata = 8'h02; step();
        match_wr = 3'b010; match_wdata = 8'h0A; step();
        match_wr = '0;
        chk("idle_wr_mv", 32'(match_value), 32'h000A02);
        chk("idle_wr_pend", 32'(shadow_pend), 32'(0));

        // presc=0, period=4 free run
        start = 1'b1; step(); start = 1'b0;
        chk("start_en", 32'(en), 32'(1));
        chk("start_cnt", 32'(counter_value), 32'(0));
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("run_cnt", 32'(counter_value), 32'(k % 5));
            chk("run_ovf", 32'(overflow), 32'((k % 5) == 0));
            chk("run_en", 32'(en), 32'(1));
        end

        // Shadow write mid-period, transfer at wrap
        match_wr = 3'b001; match_wdata = 8'h05; step(); match_wr = '0;
        chk("sh_pend_set", 32'(shadow_pend), 32'b001);
        chk("sh_mv_hold", 32'(match_value[0]), 32'h02);
        step(); step(); step();
        chk("sh_cnt4", 32'(counter_value), 32'(4));
        chk("sh_mv_hold4", 32'(match_value[0]), 32'h02);
        step();
        chk("sh_wrap_ovf", 32'(overflow), 32'(1));
        chk("sh_wrap_mv", 32'(match_value[0]), 32'h05);
        chk("sh_wrap_pend", 32'(shadow_pend), 32'(0));

        // Write coinciding with transfer: old shadow to active, new stays pending
        step(); step();
        match_wr = 3'b100; match_wdata = 8'h09; step(); match_wr = '0;
        step();
        match_wr = 3'b100; match_wdata = 8'h07; step(); match_wr = '0;
        chk("coinc_ovf", 32'(overflow), 32'(1));
        chk("coinc_mv2", 32'(match_value[2]), 32'h09);
        chk("coinc_pend", 32'(shadow_pend), 32'b100);

        // Stop at count 3 holds, start restarts from 0
        step(); step(); step();
        chk("pre_stop_cnt", 32'(counter_value), 32'(3));
        stop = 1'b1; step(); stop = 1'b0;
        chk("stop_en", 32'(en), 32'(0));
        chk("stop_cnt", 32'(counter_value), 32'(3));
        step();
        chk("idle_hold_cnt", 32'(counter_value), 32'(3));
        start = 1'b1; step(); start = 1'b0;
        chk("restart_en", 32'(en), 32'(1));
        chk("restart_cnt", 32'(counter_value), 32'(0));
        step();
        chk("restart_cnt1", 32'(counter_value), 32'(1));
        stop = 1'b1; step();
        start = 1'b1; step(); start = 1'b0; stop = 1'b0;
        chk("startstop_en", 32'(en), 32'(0));
        chk("startstop_cnt", 32'(counter_value), 32'(1));

        // One-shot with presc=2, period=2
        presc = 8'd2; period = 8'd2; one_shot = 1'b1;
        os_cnt = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd0};
        os_ovf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        os_en  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        start = 1'b1; step(); start = 1'b0;
        chk("os_start_cnt", 32'(counter_value), 32'(0));
        for (int k = 0; k < 9; k++) begin
            step();
            chk("os_cnt", 32'(counter_value), 32'(os_cnt[k]));
            chk("os_ovf", 32'(overflow), 32'(os_ovf[k]));
            chk("os_en", 32'(en), 32'(os_en[k]));
        end
        chk("os_mv2", 32'(match_value[2]), 32'h07);
        chk("os_pend", 32'(shadow_pend), 32'(0));
        step();
        chk("os_after_cnt", 32'(counter_value), 32'(0));
        chk("os_after_en", 32'(en), 32'(0));
        chk("os_after_ovf", 32'(overflow), 32'(0));

        // Flag edge detection, set-beats-clear, W1C
        presc = 8'd0; period = 8'd200; one_shot = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        manual = 1'b1; match_force = '0; flag_clr = 3'b111; step();
        chk("flag_cleared", 32'(flag), 32'(0));
        match_force = 3'b010; flag_clr = 3'b010; step();
        chk("flag_set_wins", 32'(flag), 32'b010);
        flag_clr = '0; step();
        chk("flag_sticky", 32'(flag), 32'b010);
        flag_clr = 3'b010; step(); flag_clr = '0;
        chk("flag_w1c", 32'(flag), 32'(0));
        step();
        chk("flag_held_noset", 32'(flag), 32'(0));
        match_force = '0; step();
        match_force = 3'b010; step();
        chk("flag_rerise", 32'(flag), 32'b010);
        chk("flag_pre_cnt", 32'(counter_value), 32'(7));

        // Period lowered below count: natural 8-bit wrap without overflow
        period = 8'd3;
        prev = counter_value; ovf_seen = 0; hit_zero = 1'b0;
        for (int k = 0; k < 300 && !hit_zero; k++) begin
            prev = counter_value;
            step();
            if (overflow) ovf_seen++;
            if (counter_value == 8'd0) hit_zero = 1'b1;
        end
        chk("wrap_reached", 32'(hit_zero), 32'(1));
        chk("wrap_prev255", 32'(prev), 32'hFF);
        chk("wrap_no_ovf", 32'(ovf_seen), 32'(0));
        step(); step(); step();
        chk("wrap_cnt3", 32'(counter_value), 32'(3));
        step();
        chk("wrap_then_ovf", 32'(overflow), 32'(1));
        chk("wrap_then_cnt", 32'(counter_value), 32'(0));

        // Reset mid-run with flag and pending shadow
        match_wr = 3'b001; match_wdata = 8'h33; step(); match_wr = '0;
        chk("prerst_pend", 32'(shadow_pend), 32'b001);
        chk("prerst_flag1", 32'(flag[1]), 32'(1));
        rst = 1'b1; step(); rst = 1'b0;
        chk("mrst_en", 32'(en), 32'(0));
        chk("mrst_cnt", 32'(counter_value), 32'(0));
        chk("mrst_mv", 32'(match_value), 32'(0));
        chk("mrst_flag", 32'(flag), 32'(0));
        chk("mrst_ovf", 32'(overflow), 32'(0));
        chk("mrst_pend", 32'(shadow_pend), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
